// File: rtl/inst_encoder_pkg.sv
// Shared instruction-set definitions for the encoder (and the matching decoder):
// op class encodings, MIPS opcode/funct constants, the output-buffer occupancy
// states and the field-to-word encoding function.
package inst_encoder_pkg;

  // Decoded op class carried on the request stream
  typedef enum logic [2:0] {
    op_addu = 3'd0,
    op_subu = 3'd1,
    op_ori  = 3'd2,
    op_lw   = 3'd3,
    op_sw   = 3'd4,
    op_beq  = 3'd5,
    op_jal  = 3'd6,
    op_und  = 3'd7
  } op_e;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  // R-type function codes (instruction bits 5:0)
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  // Occupancy of the 2-entry output buffer
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // Re-encode a decoded instruction into its 32-bit MIPS word. Fields that an
  // op does not use are ignored; the undefined op yields zero (never stored).
  function automatic logic [31:0] encode_inst(
    input logic [2:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    case (op)
      op_addu: word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_ADDU};
      op_subu: word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FN_SUBU};
      op_ori:  word = {OPC_ORI, rs, rt, imm};
      op_lw:   word = {OPC_LW,  rs, rt, imm};
      op_sw:   word = {OPC_SW,  rs, rt, imm};
      op_beq:  word = {OPC_BEQ, rs, rt, imm};
      op_jal:  word = {OPC_JAL, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request stream (decoded fields + address load) and instruction-memory write
// stream of the encoder, plus its status outputs.
interface inst_encoder_if #(
  parameter int CNT_W = 16
);
  // Request side
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              addr_load;
  logic [31:0]       addr_in;
  // Memory write side
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       waddr;
  logic [31:0]       wdata;
  // Status
  logic [CNT_W-1:0]  words_written;
  logic              err_und;

  // Loader / bench / memory side
  modport master (
    output in_valid, op, rs, rt, rd, imm, target, addr_load, addr_in, out_ready,
    input  in_ready, out_valid, waddr, wdata, words_written, err_und
  );

  // Encoder side
  modport slave (
    input  in_valid, op, rs, rt, rd, imm, target, addr_load, addr_in, out_ready,
    output in_ready, out_valid, waddr, wdata, words_written, err_und
  );
endinterface

// File: rtl/inst_encoder_fifo2.sv
// Two-entry in-order valid/ready buffer. The head entry is a register that
// drives pop_data directly; push_ready and pop_valid are registered, so there
// is no combinational path from pop_ready to push_ready.
import inst_encoder_pkg::*;

module inst_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  fifo_state_e  state_r;
  fifo_state_e  state_nxt_s;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         ready_r;
  logic         valid_r;
  logic         push_fire_s;
  logic         pop_fire_s;
  logic         load_head_s;
  logic         head_from_tail_s;
  logic         load_tail_s;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FIFO_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next occupancy and entry-load controls from the push/pop handshakes
  always_comb begin
    state_nxt_s      = state_r;
    load_head_s      = 1'b0;
    head_from_tail_s = 1'b0;
    load_tail_s      = 1'b0;
    push_fire_s      = push_valid & ready_r;
    pop_fire_s       = valid_r & pop_ready;
    case (state_r)
      FIFO_EMPTY: begin
        if (push_fire_s) begin
          load_head_s = 1'b1;
          state_nxt_s = FIFO_ONE;
        end else begin
          state_nxt_s = FIFO_EMPTY;
        end
      end
      FIFO_ONE: begin
        if (push_fire_s && pop_fire_s) begin
          load_head_s = 1'b1;
          state_nxt_s = FIFO_ONE;
        end else if (push_fire_s) begin
          load_tail_s = 1'b1;
          state_nxt_s = FIFO_FULL;
        end else if (pop_fire_s) begin
          state_nxt_s = FIFO_EMPTY;
        end else begin
          state_nxt_s = FIFO_ONE;
        end
      end
      FIFO_FULL: begin
        // push_ready is low here, so only a pop can happen
        if (pop_fire_s) begin
          head_from_tail_s = 1'b1;
          state_nxt_s      = FIFO_ONE;
        end else begin
          state_nxt_s = FIFO_FULL;
        end
      end
      default: begin
        state_nxt_s = FIFO_EMPTY;
      end
    endcase
  end

  // Entry storage: head feeds the output, tail holds the second word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {W{1'b0}};
      tail_r <= {W{1'b0}};
    end else begin
      if (load_head_s) begin
        head_r <= push_data;
      end else if (head_from_tail_s) begin
        head_r <= tail_r;
      end else begin
        head_r <= head_r;
      end
      if (load_tail_s) begin
        tail_r <= push_data;
      end else begin
        tail_r <= tail_r;
      end
    end
  end

  // Registered handshake flags; ready stays low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s != FIFO_FULL);
      valid_r <= (state_nxt_s != FIFO_EMPTY);
    end
  end

  assign push_ready = ready_r;
  assign pop_valid  = valid_r;
  assign pop_data   = head_r;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: turns decoded instruction fields back into MIPS words
// and streams them out as addressed instruction-memory writes. Tracks the next
// write address, counts words taken by memory and flags undefined ops.
import inst_encoder_pkg::*;

module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_encoder_if.slave bus
);

  logic             accept_s;
  logic             und_s;
  logic             push_s;
  logic             pop_fire_s;
  logic             push_ready_s;
  logic             pop_valid_s;
  logic [31:0]      load_addr_s;
  logic [31:0]      word_addr_s;
  logic [31:0]      word_data_s;
  logic [63:0]      push_data_s;
  logic [63:0]      pop_data_s;
  logic [31:0]      next_addr_r;
  logic [CNT_W-1:0] words_written_r;
  logic             err_und_r;

  // Request handshake, address selection and word encoding
  always_comb begin
    accept_s    = bus.in_valid & push_ready_s;
    und_s       = (bus.op == op_und);
    push_s      = accept_s & ~und_s;
    pop_fire_s  = pop_valid_s & bus.out_ready;
    load_addr_s = {bus.addr_in[31:2], 2'b00};
    if (bus.addr_load) begin
      word_addr_s = load_addr_s;
    end else begin
      word_addr_s = next_addr_r;
    end
    word_data_s = encode_inst(bus.op, bus.rs, bus.rt, bus.rd, bus.imm, bus.target);
    push_data_s = {word_addr_s, word_data_s};
  end

  inst_fifo2 #(
    .W (64)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_s),
    .push_ready (push_ready_s),
    .push_data  (push_data_s),
    .pop_valid  (pop_valid_s),
    .pop_ready  (bus.out_ready),
    .pop_data   (pop_data_s)
  );

  // Next write address: advance past each stored word, or take a loaded one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_r <= BASE_ADDR;
    end else if (push_s) begin
      next_addr_r <= word_addr_s + 32'd4;
    end else if (bus.addr_load) begin
      next_addr_r <= load_addr_s;
    end else begin
      next_addr_r <= next_addr_r;
    end
  end

  // Sticky undefined-op flag, set on an accepted op=7 request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_und_r <= 1'b0;
    end else if (accept_s && und_s) begin
      err_und_r <= 1'b1;
    end else begin
      err_und_r <= err_und_r;
    end
  end

  // Count of words taken by memory, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_written_r <= {CNT_W{1'b0}};
    end else if (pop_fire_s) begin
      words_written_r <= words_written_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      words_written_r <= words_written_r;
    end
  end

  assign bus.in_ready      = push_ready_s;
  assign bus.out_valid     = pop_valid_s;
  assign bus.waddr         = pop_data_s[63:32];
  assign bus.wdata         = pop_data_s[31:0];
  assign bus.words_written = words_written_r;
  assign bus.err_und       = err_und_r;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the pipeline's instruction decoder: accepts a decoded instruction (3-bit op class plus rs/rt/rd/imm/target fields) over a valid/ready stream.
- Re-encodes each instruction to a 32-bit MIPS word and emits it as an addressed instruction-memory write stream.
- Used by the bench program loader and the self-test to fill instruction memory ahead of the pipeline.
- Contains a 2-entry output buffer, a byte-address counter, a write counter and a sticky error flag.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first write after reset.
- CNT_W, 16, width of the written-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction fields are valid.
- in_ready  output  1  encoder can accept this cycle.
- op  input  3  0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 jal, 7 undefined.
- rs  input  5  source register.
- rt  input  5  target register.
- rd  input  5  destination register.
- imm  input  16  immediate / offset.
- target  input  26  jump target.
- addr_load  input  1  load addr_in as the next write address.
- addr_in  input  32  new byte address (bits 1:0 ignored, forced to 0).
- out_valid  output  1  wdata/waddr are valid.
- out_ready  input  1  memory accepts the word.
- waddr  output  32  byte address of the word.
- wdata  output  32  encoded instruction.
- words_written  output  CNT_W  count of words accepted by memory.
- err_und  output  1  sticky: an op=7 request was received.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, in_ready=0 while rst_n is low, in_ready=1 from the first cycle after release.
  - waddr=0, wdata=0.
  - words_written=0, err_und=0.
  - Buffer empty; next address = BASE_ADDR.
  - Reset mid-transfer drops all buffered words.
- Accept: a request is accepted when in_valid & in_ready. in_ready = buffer not full, registered (no combinational path from out_ready).
- Encoding (pure function, evaluated on accept):
  - addu: {6'b000000, rs, rt, rd, 5'b0, 6'b100001}
  - subu: same layout, funct 6'b100011
  - ori: {6'b001101, rs, rt, imm}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - jal: {6'b000011, target}
  - Fields unused by an op are ignored.
- Undefined op (7): request is accepted (handshake completes) and dropped. It is not buffered, the address does not advance, and err_und is set to 1 and held until reset.
- Address:
  - Each accepted defined instruction is tagged with the current next-address, then next-address += 4.
  - Wraps 32'hFFFF_FFFC -> 0.
  - addr_load in the same cycle as an accept: the accepted word takes {addr_in[31:2],2'b00}, and next-address becomes that value + 4.
  - addr_load alone: next-address = {addr_in[31:2],2'b00}.
  - addr_load never alters words already buffered.
- Buffer: 2-entry FIFO, in order.
  - Latency: accept at cycle N -> out_valid at N+1 if the buffer was empty.
  - Sustains 1 word/cycle with out_ready held high.
  - Simultaneous push and pop when full is not possible (in_ready=0). Push and pop when 1 entry is held keeps the count at 1.
- Output: waddr/wdata hold stable while out_valid & !out_ready.
- words_written: increments on out_valid & out_ready and wraps modulo 2^CNT_W.

Decomposition:
- Shared package (shared with the decoder):
  - op encodings op_addu..op_und.
  - 6-bit opcode constants OPC_RTYPE, OPC_ORI, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL.
  - funct constants FN_ADDU, FN_SUBU.
- Sub-module inst_fifo2: 2-entry, 64-bit wide ({addr,data}) valid/ready FIFO with registered full/empty.
- Encoder case logic and address/error/counter logic stay in the top level.

Test Plan:
- Reset then addu rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_valid=1, waddr=0x00003000, wdata=0x00221821; words_written=1.
- Back-to-back stream subu(1,2,3), ori rs=0 rt=1 imm=0x1234, lw rs=1 rt=2 imm=4, sw same, beq imm=0xFFFF, jal target=0xC00 -> wdata 0x00221823, 0x34011234, 0x8C220004, 0xAC220004, 0x1022FFFF, 0x0C000C00 at 0x3000..0x3014, one per cycle.
- Backpressure:
  - out_ready=0, three requests -> in_ready drops after two accepts; output holds 0x3000 stable.
  - Release -> words drain in order; the third is accepted and lands at 0x3008.
- op=7 between two addu -> err_und=1 and stays 1; the two addu words land at 0x3000 and 0x3004 (no gap).
- addr_load=1, addr_in=0xFFFF_FFFE, with accept -> word at 0xFFFFFFFC; next word at 0x00000000.
- rst_n pulsed low with two words buffered -> out_valid=0 immediately; after release, next word at 0x3000 and words_written=0.
